// File: rtl/mod_reduce_seq.sv
// mod_reduce_seq: sequential (X * SCALE) mod MOD reducer.
// The operand is consumed MSB-first in CHUNK_W-bit digits by Horner iteration.
// An optional final constant multiply is then applied. One operand is in flight at a time.
module mod_reduce_seq #(
  parameter int MOD     = 241,
  parameter int IN_W    = 400,
  parameter int CHUNK_W = 6,
  parameter int RES_W   = 8,
  parameter int SCALE   = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_W-1:0]    in_data,
  input  logic               in_scale_en,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [RES_W-1:0]   out_data,
  output logic               busy
);

  localparam int NSTEP    = (IN_W + CHUNK_W - 1) / CHUNK_W;
  localparam int PAD_W    = NSTEP * CHUNK_W;
  localparam int STEP_W   = $clog2(NSTEP + 1);
  localparam int HORNER_W = RES_W + CHUNK_W + 1;
  localparam int PROD_W   = 2 * RES_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_SCALE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t              state_reg;
  state_t              state_next;
  logic [PAD_W-1:0]    shift_reg;
  logic [RES_W-1:0]    r_reg;
  logic [STEP_W-1:0]   step_reg;
  logic                scale_en_reg;

  logic [CHUNK_W-1:0]  digit;
  logic [HORNER_W-1:0] horner_sum;
  logic [RES_W-1:0]    horner_res;
  logic [RES_W-1:0]    factor;
  logic [PROD_W-1:0]   prod;
  logic [RES_W-1:0]    scale_res;
  logic                last_step;

  // Horner step and final scale arithmetic; both reductions are exact since r < MOD.
  always_comb begin
    digit      = shift_reg[PAD_W-1 -: CHUNK_W];
    horner_sum = (HORNER_W'(r_reg) << CHUNK_W) | HORNER_W'(digit);
    horner_res = RES_W'(horner_sum % HORNER_W'(MOD));
    factor     = scale_en_reg ? RES_W'(SCALE) : RES_W'(1);
    prod       = PROD_W'(r_reg) * PROD_W'(factor);
    scale_res  = RES_W'(prod % PROD_W'(MOD));
    last_step  = (step_reg == STEP_W'(NSTEP - 1));
  end

  // State register; reset overrides every state and drops any operand in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs. in_ready is masked during reset so nothing is accepted.
  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    out_data   = '0;
    case (state_reg)
      S_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          state_next = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (last_step) begin
          state_next = S_SCALE;
        end
      end
      S_SCALE: begin
        busy       = 1'b1;
        state_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        out_data  = r_reg;
        if (out_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Datapath: latch operand on accept, shift one digit per RUN cycle, scale once.
  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg    <= '0;
      r_reg        <= '0;
      step_reg     <= '0;
      scale_en_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (in_valid) begin
            shift_reg    <= PAD_W'(in_data);
            scale_en_reg <= in_scale_en;
            r_reg        <= '0;
            step_reg     <= '0;
          end
        end
        S_RUN: begin
          r_reg     <= horner_res;
          shift_reg <= shift_reg << CHUNK_W;
          step_reg  <= step_reg + STEP_W'(1);
        end
        S_SCALE: begin
          r_reg <= scale_res;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mod_reduce_seq.sv
// Directed bench for mod_reduce_seq at default parameters (MOD=241, IN_W=400, CHUNK_W=6, SCALE=64).
module tb_mod_reduce_seq;

  localparam int IN_W  = 400;
  localparam int RES_W = 8;
  localparam int LAT   = 68;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_data;
  logic              in_scale_en;
  logic              out_valid;
  logic              out_ready;
  logic [RES_W-1:0]  out_data;
  logic              busy;

  int n_cmp;
  int n_err;

  mod_reduce_seq dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_scale_en (in_scale_en),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial reference: X mod 241 one bit at a time, then optional *64.
  function automatic int model(input logic [IN_W-1:0] x, input logic en);
    int r;
    r = 0;
    for (int i = IN_W - 1; i >= 0; i--) begin
      r = (r * 2 + int'(x[i])) % 241;
    end
    if (en) r = (r * 64) % 241;
    return r;
  endfunction

  // Offer one operand, wait for out_valid (bounded). Leaves the block in DONE, un-handshaken.
  task automatic run_op(input logic [IN_W-1:0] x, input logic en,
                        output logic [RES_W-1:0] res, output int lat, output int busy_cnt);
    int t;
    t = 0;
    res = '0;
    lat = 0;
    busy_cnt = 0;
    while (!in_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      n_cmp++; n_err++;
      $display("FAIL accept_timeout: in_ready=%0b required 1", in_ready);
      return;
    end
    in_valid = 1'b1;
    in_data = x;
    in_scale_en = en;
    @(negedge clk);
    in_valid = 1'b0;
    in_data = ~x;            // must be ignored while busy
    in_scale_en = ~en;
    busy_cnt = busy ? 1 : 0;
    while (!out_valid && lat < 300) begin
      @(negedge clk);
      lat++;
      if (busy) busy_cnt++;
    end
    if (!out_valid) begin
      n_cmp++; n_err++;
      $display("FAIL result_timeout: out_valid=%0b required 1", out_valid);
    end
    res = out_data;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;          // ignored during reset
    in_data = '1;
    in_scale_en = 1'b1;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0b required 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0b required 0", out_valid); end
    n_cmp++; if (out_data !== 8'd0) begin n_err++; $display("FAIL rst_out_data: got %0d required 0", out_data); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b required 0", busy); end
    in_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL post_rst_in_ready: got %0b required 1", in_ready); end
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL post_rst_busy: got %0b required 0", busy); end
  endtask

  task automatic test_zero();
    logic [RES_W-1:0] res;
    int lat, bc;
    run_op('0, 1'b0, res, lat, bc);
    $display("op X=0 en=0 -> %0d lat=%0d busy=%0d", res, lat, bc);
    n_cmp++; if (res !== 8'd0) begin n_err++; $display("FAIL zero_result: got %0d required 0", res); end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL zero_latency: got %0d required %0d", lat, LAT); end
    n_cmp++; if (bc != LAT) begin n_err++; $display("FAIL zero_busy_cycles: got %0d required %0d", bc, LAT); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL done_in_ready: got %0b required 0", in_ready); end
    handshake();
    n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL zero_valid_drop: got %0b required 0", out_valid); end
  endtask

  task automatic test_vectors();
    logic [IN_W-1:0] xs [7];
    logic            ens [7];
    int              exps [7];
    logic [RES_W-1:0] res;
    int lat, bc;
    xs[0] = IN_W'(241);   ens[0] = 1'b1; exps[0] = 0;
    xs[1] = IN_W'(240);   ens[1] = 1'b0; exps[1] = 240;
    xs[2] = IN_W'(1);     ens[2] = 1'b1; exps[2] = 64;
    xs[3] = '1;           ens[3] = 1'b0; exps[3] = 224;
    xs[4] = '1;           ens[4] = 1'b1; exps[4] = 117;
    xs[5] = '0; xs[5][IN_W-1] = 1'b1; ens[5] = 1'b0; exps[5] = 233;
    xs[6] = xs[5];        ens[6] = 1'b1; exps[6] = 211;
    for (int i = 0; i < 7; i++) begin
      run_op(xs[i], ens[i], res, lat, bc);
      $display("op vec%0d en=%0b -> %0d (want %0d) lat=%0d", i, ens[i], res, exps[i], lat);
      n_cmp++; if (int'(res) != exps[i]) begin n_err++; $display("FAIL vec%0d_result: got %0d required %0d", i, res, exps[i]); end
      n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL vec%0d_latency: got %0d required %0d", i, lat, LAT); end
      handshake();
    end
    run_op(IN_W'(723), 1'b0, res, lat, bc);
    $display("op X=723 en=0 -> %0d", res);
    n_cmp++; if (res !== 8'd0) begin n_err++; $display("FAIL multiple_of_mod: got %0d required 0", res); end
    handshake();
  endtask

  task automatic test_stall_back_to_back();
    logic [RES_W-1:0] res;
    int lat, bc, bad;
    run_op(IN_W'(240), 1'b0, res, lat, bc);
    bad = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_data !== 8'd240 || in_ready !== 1'b0) bad++;
    end
    $display("op stall X=240 -> %0d, unstable cycles=%0d", out_data, bad);
    n_cmp++; if (bad != 0) begin n_err++; $display("FAIL stall_hold: got %0d unstable cycles required 0", bad); end
    n_cmp++; if (out_data !== 8'd240) begin n_err++; $display("FAIL stall_data: got %0d required 240", out_data); end
    handshake();
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready: got %0b required 1", in_ready); end
    run_op(IN_W'(1), 1'b1, res, lat, bc);
    $display("op b2b X=1 en=1 -> %0d lat=%0d", res, lat);
    n_cmp++; if (res !== 8'd64) begin n_err++; $display("FAIL b2b_result: got %0d required 64", res); end
    n_cmp++; if (lat != LAT) begin n_err++; $display("FAIL b2b_latency: got %0d required %0d", lat, LAT); end
    handshake();
  endtask

  task automatic test_rst_mid_run();
    logic [RES_W-1:0] res;
    int lat, bc, pulses;
    in_valid = 1'b1;
    in_data = '1;
    in_scale_en = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL midrst_busy: got %0b required 0", busy); end
    n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL midrst_in_ready: got %0b required 0", in_ready); end
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 80; c++) begin
      @(negedge clk);
      if (out_valid) pulses++;
    end
    $display("op midrun reset -> out_valid pulses=%0d", pulses);
    n_cmp++; if (pulses != 0) begin n_err++; $display("FAIL midrst_no_output: got %0d pulses required 0", pulses); end
    n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL midrst_idle: got in_ready=%0b required 1", in_ready); end
    run_op(IN_W'(1), 1'b1, res, lat, bc);
    $display("op post-reset X=1 en=1 -> %0d", res);
    n_cmp++; if (res !== 8'd64) begin n_err++; $display("FAIL midrst_fresh: got %0d required 64", res); end
    handshake();
  endtask

  task automatic test_random();
    logic [IN_W-1:0] x;
    logic en;
    logic [RES_W-1:0] res;
    int lat, bc, exp_v;
    for (int n = 0; n < 30; n++) begin
      for (int w = 0; w < 12; w++) x[w*32 +: 32] = $urandom;
      x[399:384] = 16'($urandom);
      en = 1'($urandom);
      exp_v = model(x, en);
      run_op(x, en, res, lat, bc);
      $display("op rand%0d en=%0b -> %0d (want %0d)", n, en, res, exp_v);
      n_cmp++; if (int'(res) != exp_v) begin n_err++; $display("FAIL rand%0d_result: got %0d required %0d", n, res, exp_v); end
      handshake();
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_scale_en = 1'b0;
    out_ready = 1'b0;
    test_reset();
    test_zero();
    test_vectors();
    test_stall_back_to_back();
    test_rst_mid_run();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
